uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer and launch scheduler sitting directly upstream of UART_TX.
//  Accepts bytes from a host write port at up to one per clock, stores them in
//  a DEPTH-entry FIFO, and hands them one at a time to UART_TX on its
//  i_TX_DV/i_TX_Byte interface. Waits for each frame to finish (i_TX_Done)
//  before launching the next, so host bursts never collide with a frame in flight.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >= 2
//  ADDR_W  4   log2(DEPTH); pointer width (count width is ADDR_W+1)
// PORTS
//  i_Clock      in   1         system clock; all logic on posedge
//  i_Reset      in   1         synchronous, active-high reset
//  i_Wr_DV      in   1         host write strobe; one byte per cycle asserted
//  i_Wr_Byte    in   8         host data, sampled when i_Wr_DV=1
//  o_Full       out  1         count == DEPTH
//  o_Empty      out  1         count == 0
//  o_Count      out  ADDR_W+1  bytes currently stored, 0..DEPTH
//  o_Overflow   out  1         one-cycle pulse: a write was dropped
//  o_TX_DV      out  1         to UART_TX i_TX_DV; one-cycle launch pulse
//  o_TX_Byte    out  8         to UART_TX i_TX_Byte; valid while o_TX_DV=1
//  i_TX_Active  in   1         from UART_TX o_TX_Active
//  i_TX_Done    in   1         from UART_TX o_TX_Done (one-cycle pulse)
// BEHAVIOUR
//  Reset: ptrs=0, count=0, FSM=IDLE, o_Empty=1, o_Full=0, o_Count=0,
//   o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00. Stored contents discarded.
//   A frame already in progress inside UART_TX is not aborted.
//  Reset has priority over every other input in the same cycle.
//  All outputs are registered.
//  Write: accepted when i_Wr_DV=1 and (count<DEPTH or a pop occurs that cycle).
//   Dropped otherwise -> o_Overflow=1 the next cycle; FIFO contents unchanged.
//  Pop: occurs only on the IDLE->LAUNCH transition (see FSM).
//  Count: write only +1; pop only -1; write+pop 0.
//  Pointers: wrap modulo DEPTH with no special case.
//  FSM (states in package):
//   IDLE    if count!=0: o_TX_DV<=1, o_TX_Byte<=mem[rd_ptr], pop, ->LAUNCH
//   LAUNCH  o_TX_DV<=0; ->WAIT_ACT
//   WAIT_ACT wait i_TX_Active=1 -> WAIT_DONE
//   WAIT_DONE wait i_TX_Done=1 -> GAP
//   GAP     one cycle so UART_TX returns to idle; ->IDLE
//  o_TX_DV is never high outside the cycle following IDLE, and never twice per frame.
//  Latency: write sampled at edge N into empty FIFO, FSM in IDLE ->
//   o_Count=1 after N; o_TX_DV high after edge N+1 (count back to 0).
//  Back-to-back frames: next o_TX_DV at earliest 2 cycles after i_TX_Done.
//  Bytes leave in write order; no byte is duplicated or skipped.
// STRUCTURE
//  uart_pkg: FSM state localparams (IDLE, LAUNCH, WAIT_ACT, WAIT_DONE, GAP),
//   BYTE_W=8.
//  Sub-module uart_sync_fifo (DEPTH/ADDR_W): memory, pointers, count, full/empty,
//   overflow. Inputs: wr_en/wr_data/rd_en; outputs: rd_data = mem[rd_ptr].
//  The top level holds the FSM and the UART_TX handshake only.
// TESTING (25 MHz clock, UART_TX + UART_RX CLKS_PER_BIT=217, loopback line)
//  1 Reset held 3 cycles -> o_Empty=1, o_Count=0, o_TX_DV=0, o_Overflow=0.
//  2 Write 8'h3F at edge N -> o_TX_DV high after N+1 for exactly 1 cycle;
//    UART_RX o_RX_Byte=8'h3F.
//  3 Writes 8'h11,8'h22,8'h33 on consecutive cycles -> exactly 3 o_TX_DV pulses,
//    none while i_TX_Active=1; RX sees 11,22,33 in order.
//  4 17 consecutive writes 8'h00..8'h10 while UART_TX busy -> o_Full=1;
//    one o_Overflow pulse for the dropped byte; that byte is never received;
//    all stored bytes are received.
//  5 With count=16 (o_Full=1), write 8'hEE in the same cycle as the IDLE pop ->
//    write accepted, o_Count stays 16, no o_Overflow; 8'hEE transmitted last.
//  6 Load 4 bytes, assert i_Reset mid-frame -> count=0 next cycle; in-flight
//    frame completes on the line; no further o_TX_DV pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART transmit buffer path.
// Latency: n/a (package). Backpressure: n/a.
// Holds the launch-scheduler state encoding and the byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACT,
        WAIT_DONE,
        GAP
    } tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered count/full/empty and a drop pulse.
// Latency: a write is visible in count and rd_data one clock after it is sampled.
// Backpressure: a write while full is dropped (overflow next cycle) unless a read frees a slot that cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_ok;
    logic              wr_ok;
    logic [ADDR_W:0]   count_nxt;

    // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + ONE_CNT;
            2'b01:   count_nxt = count - ONE_CNT;
            default: count_nxt = count;
        endcase
    end

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt;
            full     <= (count_nxt == FULL_CNT);
            empty    <= (count_nxt == '0);
            overflow <= wr_en && !wr_ok;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and launches them one frame at a time into UART_TX.
// Latency: byte written into an empty idle buffer at edge N launches (o_TX_DV) after edge N+1.
// Backpressure: none toward the host; writes beyond DEPTH are dropped and flagged on o_Overflow.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_DV,
    input  logic [BYTE_W-1:0] i_Wr_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_TX_DV,
    output logic [BYTE_W-1:0] o_TX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done
);

    tx_state_t         state;
    logic              pop;
    logic [BYTE_W-1:0] head_byte;

    assign pop = (state == IDLE) && !o_Empty;

    uart_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .wr_en    (i_Wr_DV),
        .wr_data  (i_Wr_Byte),
        .rd_en    (pop),
        .rd_data  (head_byte),
        .count    (o_Count),
        .full     (o_Full),
        .empty    (o_Empty),
        .overflow (o_Overflow)
    );

    // Handshake waits for Active before Done so a stale Done cannot end a fresh frame.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state     <= IDLE;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_TX_DV   <= 1'b1;
                        o_TX_Byte <= head_byte;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    o_TX_DV <= 1'b0;
                    state   <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    if (i_TX_Active) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_TX_Done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    o_TX_DV <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
